// File: rtl/cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_adder
// Brief    : Registered N-bit two's-complement adder/subtractor on a
//            4-bit-group carry-lookahead network; sum/carry/overflow one
//            cycle after the operands are accepted.
// Revision : 1.0 - initial release
// ============================================================================
module cla_adder #(
    parameter int N     = 8,   // multiple of 4, at least 4
    parameter int GROUP = 4    // lookahead group size; equations below assume 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         sub,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         out_valid,
    output logic [N-1:0] sum,
    output logic         carry,
    output logic         overflow
);

    localparam int c_NUM_GROUPS = N / GROUP;

    logic [N-1:0] w_yb;
    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N:0]   w_c;
    logic [N-1:0] w_sum;
    logic         w_ovf;

    logic [N-1:0] r_sum;
    logic         r_carry;
    logic         r_ovf;
    logic         r_valid;

    // Subtraction is x + ~y + 1: invert y and inject sub as the carry-in.
    assign w_yb   = y ^ {N{sub}};
    assign w_g    = x & w_yb;
    assign w_p    = x ^ w_yb;
    assign w_c[0] = sub;

    // Each group resolves its internal carries in two levels of logic; the
    // group carry-out is formed from (G, P) and rippled group-to-group.
    generate
        for (genvar gi = 0; gi < c_NUM_GROUPS; gi++) begin : g_group
            localparam int c_B = gi * GROUP;

            logic [3:0] w_gg;
            logic [3:0] w_pg;
            logic       w_cin;
            logic       w_grp_g;
            logic       w_grp_p;

            assign w_gg  = w_g[c_B +: 4];
            assign w_pg  = w_p[c_B +: 4];
            assign w_cin = w_c[c_B];

            assign w_c[c_B+1] = w_gg[0]
                              | (w_pg[0] & w_cin);
            assign w_c[c_B+2] = w_gg[1]
                              | (w_pg[1] & w_gg[0])
                              | (w_pg[1] & w_pg[0] & w_cin);
            assign w_c[c_B+3] = w_gg[2]
                              | (w_pg[2] & w_gg[1])
                              | (w_pg[2] & w_pg[1] & w_gg[0])
                              | (w_pg[2] & w_pg[1] & w_pg[0] & w_cin);

            assign w_grp_g = w_gg[3]
                           | (w_pg[3] & w_gg[2])
                           | (w_pg[3] & w_pg[2] & w_gg[1])
                           | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0]);
            assign w_grp_p = &w_pg;

            assign w_c[c_B+4] = w_grp_g | (w_grp_p & w_cin);
        end
    endgenerate

    assign w_sum = w_p ^ w_c[N-1:0];
    assign w_ovf = w_c[N] ^ w_c[N-1];

    // Results hold across idle cycles; only out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum   <= w_sum;
                r_carry <= w_c[N];
                r_ovf   <= w_ovf;
            end
        end
    end

    assign sum       = r_sum;
    assign carry     = r_carry;
    assign overflow  = r_ovf;
    assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_adder
// Brief    : Self-checking bench for cla_adder: directed table with a
//            scoreboard queue, exhaustive 8-bit sweep, random 16/32-bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_adder;

    localparam int c_EXH_INST = 8;
    localparam int c_EXH_SPAN = 16384;   // 2^17 vectors split over 8 instances
    localparam int c_RAND_CNT = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       sub;
    logic [7:0] x;
    logic [7:0] y;
    logic       out_valid;
    logic [7:0] sum;
    logic       carry;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       sub;
        logic [7:0] sum;
        logic       c;
        logic       o;
    } vec_t;

    typedef struct {
        logic [7:0] sum;
        logic       c;
        logic       o;
    } exp_t;

    exp_t sb_q[$];
    exp_t held;
    logic exp_valid;

    cla_adder #(.N(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sub(sub), .x(x), .y(y),
        .out_valid(out_valid), .sum(sum), .carry(carry), .overflow(overflow)
    );

    // Exhaustive 8-bit instances, each sweeping one slice of {sub, x, y}.
    logic       ex_v;
    logic [7:0] ex_x   [c_EXH_INST];
    logic [7:0] ex_y   [c_EXH_INST];
    logic       ex_s   [c_EXH_INST];
    logic       ex_ov  [c_EXH_INST];
    logic [7:0] ex_sum [c_EXH_INST];
    logic       ex_c   [c_EXH_INST];
    logic       ex_o   [c_EXH_INST];

    generate
        for (genvar gj = 0; gj < c_EXH_INST; gj++) begin : g_exh
            cla_adder #(.N(8)) u_exh (
                .clk(clk), .rst(rst), .in_valid(ex_v), .sub(ex_s[gj]),
                .x(ex_x[gj]), .y(ex_y[gj]), .out_valid(ex_ov[gj]),
                .sum(ex_sum[gj]), .carry(ex_c[gj]), .overflow(ex_o[gj])
            );
        end
    endgenerate

    logic        r16_s, r16_ov, r16_c, r16_o;
    logic [15:0] r16_x, r16_y, r16_sum;
    logic        r32_s, r32_ov, r32_c, r32_o;
    logic [31:0] r32_x, r32_y, r32_sum;

    cla_adder #(.N(16)) u_r16 (
        .clk(clk), .rst(rst), .in_valid(ex_v), .sub(r16_s), .x(r16_x), .y(r16_y),
        .out_valid(r16_ov), .sum(r16_sum), .carry(r16_c), .overflow(r16_o)
    );

    cla_adder #(.N(32)) u_r32 (
        .clk(clk), .rst(rst), .in_valid(ex_v), .sub(r32_s), .x(r32_x), .y(r32_y),
        .out_valid(r32_ov), .sum(r32_sum), .carry(r32_c), .overflow(r32_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Golden model: plain bit-serial ripple-carry adder.
    task automatic ripple(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic s, output logic [31:0] r, output logic c,
                          output logic o);
        logic cin, cprev, bb;
        cin   = s;
        cprev = s;
        r     = '0;
        for (int i = 0; i < w; i++) begin
            bb    = b[i] ^ s;
            r[i]  = a[i] ^ bb ^ cin;
            cprev = cin;
            cin   = (a[i] & bb) | (a[i] & cin) | (bb & cin);
        end
        c = cin;
        o = cin ^ cprev;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] a,
                         input logic [7:0] b, input exp_t e);
        in_valid = v;
        sub      = s;
        x        = a;
        y        = b;
        if (v && !rst) sb_q.push_back(e);
    endtask

    task automatic drive_model(input logic v, input logic s, input logic [7:0] a,
                               input logic [7:0] b);
        logic [31:0] r;
        logic        c, o;
        exp_t        e;
        ripple(8, {24'd0, a}, {24'd0, b}, s, r, c, o);
        e = '{r[7:0], c, o};
        drive(v, s, a, b, e);
    endtask

    task automatic tick();
        logic was_rst, was_v;
        was_rst = rst;
        was_v   = in_valid;
        @(posedge clk);
        #1;
        if (was_rst) begin
            sb_q.delete();
            held      = '{8'd0, 1'b0, 1'b0};
            exp_valid = 1'b0;
        end else if (was_v) begin
            if (sb_q.size() > 0) held = sb_q.pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        check("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
        check("sum_carry_ovf", {54'd0, sum, carry, overflow}, {54'd0, held.sum, held.c, held.o});
    endtask

    vec_t tbl[8];

    initial begin
        logic [16:0] v;
        logic [31:0] r;
        logic        c, o;

        tbl[0] = '{8'd123, 8'hB0, 1'b0, 8'd43,  1'b1, 1'b0};  // 123 + -80
        tbl[1] = '{8'hF4,  8'd53, 1'b0, 8'd41,  1'b1, 1'b0};  // -12 + 53
        tbl[2] = '{8'd8,   8'd3,  1'b0, 8'd11,  1'b0, 1'b0};
        tbl[3] = '{8'd5,   8'd8,  1'b1, 8'hFD,  1'b0, 1'b0};  // 5 - 8 = -3
        tbl[4] = '{8'd2,   8'd1,  1'b1, 8'd1,   1'b1, 1'b0};
        tbl[5] = '{8'hF4,  8'hE9, 1'b1, 8'd11,  1'b1, 1'b0};  // -12 - -23
        tbl[6] = '{8'd127, 8'd127,1'b0, 8'hFE,  1'b0, 1'b1};  // 127 + 127
        tbl[7] = '{8'd0,   8'h80, 1'b1, 8'h80,  1'b0, 1'b1};  // 0 - -128

        held      = '{8'd0, 1'b0, 1'b0};
        exp_valid = 1'b0;
        ex_v      = 1'b0;
        for (int j = 0; j < c_EXH_INST; j++) begin
            ex_x[j] = '0; ex_y[j] = '0; ex_s[j] = 1'b0;
        end
        r16_x = '0; r16_y = '0; r16_s = 1'b0;
        r32_x = '0; r32_y = '0; r32_s = 1'b0;

        // Reset wins over in_valid for two cycles.
        rst = 1'b1;
        drive_model(1'b1, 1'b0, 8'd55, 8'd66);
        tick();
        tick();

        // Directed vectors streamed back-to-back straight out of reset.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].sub, tbl[i].x, tbl[i].y, '{tbl[i].sum, tbl[i].c, tbl[i].o});
            tick();
        end
        drive_model(1'b0, 1'b0, 8'hAA, 8'h55);
        tick();
        tick();

        // Four back-to-back, idle gaps with changing operands, then a bubble.
        drive_model(1'b1, 1'b0, 8'd200, 8'd100); tick();
        drive_model(1'b1, 1'b1, 8'd100, 8'd200); tick();
        drive_model(1'b1, 1'b1, 8'h80,  8'h01);  tick();
        drive_model(1'b1, 1'b0, 8'hFF,  8'h01);  tick();
        drive_model(1'b0, 1'b1, 8'h12,  8'h34);  tick();
        drive_model(1'b0, 1'b0, 8'h56,  8'h78);  tick();
        drive_model(1'b1, 1'b0, 8'h40,  8'h40);  tick();
        drive_model(1'b0, 1'b0, 8'h00,  8'h00);  tick();
        drive_model(1'b1, 1'b1, 8'h7F,  8'hFF);  tick();

        // Reset mid-stream clears the held result.
        rst = 1'b1;
        drive_model(1'b1, 1'b0, 8'd1, 8'd1);
        tick();
        rst = 1'b0;
        drive_model(1'b1, 1'b0, 8'd9, 8'd9);
        tick();
        drive_model(1'b0, 1'b0, 8'd0, 8'd0);
        tick();
        check("queue_drained", 64'(sb_q.size()), 64'd0);

        // Exhaustive sweep of all 2^17 {sub, x, y} combinations at N=8.
        for (int n = 0; n < c_EXH_SPAN; n++) begin
            ex_v = 1'b1;
            for (int j = 0; j < c_EXH_INST; j++) begin
                v = 17'(j * c_EXH_SPAN + n);
                ex_s[j] = v[16];
                ex_x[j] = v[15:8];
                ex_y[j] = v[7:0];
            end
            @(posedge clk);
            #1;
            for (int j = 0; j < c_EXH_INST; j++) begin
                ripple(8, {24'd0, ex_x[j]}, {24'd0, ex_y[j]}, ex_s[j], r, c, o);
                check("exhaustive_n8", {53'd0, ex_ov[j], ex_sum[j], ex_c[j], ex_o[j]},
                      {53'd0, 1'b1, r[7:0], c, o});
            end
        end

        // Random vectors at N=16 and N=32.
        for (int n = 0; n < c_RAND_CNT; n++) begin
            r16_x = 16'($urandom);
            r16_y = 16'($urandom);
            r16_s = 1'($urandom_range(0, 1));
            r32_x = $urandom;
            r32_y = $urandom;
            r32_s = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            ripple(16, {16'd0, r16_x}, {16'd0, r16_y}, r16_s, r, c, o);
            check("random_n16", {45'd0, r16_ov, r16_sum, r16_c, r16_o},
                  {45'd0, 1'b1, r[15:0], c, o});
            ripple(32, r32_x, r32_y, r32_s, r, c, o);
            check("random_n32", {29'd0, r32_ov, r32_sum, r32_c, r32_o},
                  {29'd0, 1'b1, r, c, o});
        end
        ex_v = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
